// File: rtl/ttt_game_ctrl.sv
// ttt_game_ctrl
// Turn sequencer and board owner for the tic-tac-toe display. Moves a 3x3
// cursor from debounced button pulses, places X/O marks in alternating turns,
// detects wins/draws (recolouring winning cells) and answers per-cell lookups
// from the pixel pipeline.
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   btn_up/down/left/right   one-cycle cursor movement pulses
//   btn_sel                  one-cycle place / restart pulse
//   rd_cell  [3:0]           cell index requested by the pixel pipeline
//   rd_mode  [1:0]           registered cell mode: 00 empty, 01 X, 10 O, 11 win
//   rd_hl                    registered cursor highlight for rd_cell
//   cursor   [3:0]           current cursor cell, 0..8 (row*3+col)
//   turn                     0 = X to move, 1 = O to move
//   winner   [1:0]           00 none, 01 X, 10 O, 11 draw
//   game_over                1 in WIN or DRAW
module ttt_game_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_sel,
  input  logic [3:0] rd_cell,
  output logic [1:0] rd_mode,
  output logic       rd_hl,
  output logic [3:0] cursor,
  output logic       turn,
  output logic [1:0] winner,
  output logic       game_over
);

  localparam logic [2:0] PLAY_X = 3'd0;
  localparam logic [2:0] PLAY_O = 3'd1;
  localparam logic [2:0] CHECK  = 3'd2;
  localparam logic [2:0] WIN    = 3'd3;
  localparam logic [2:0] DRAW   = 3'd4;

  logic [2:0]       state;
  logic [8:0][1:0]  board;
  logic [3:0]       move_count;
  logic             mover;       // 0 = X placed last, 1 = O placed last
  logic [1:0]       mover_mark;
  logic             playing;
  logic             restart;

  logic [1:0] col;
  logic [3:0] up_pos, down_pos, left_pos, right_pos;
  logic [1:0] cur_cell;
  logic [8:0] is_mark;
  logic [7:0] line_hit;
  logic [8:0] win_cells;

  assign playing    = (state == PLAY_X) || (state == PLAY_O);
  assign mover_mark = mover ? 2'b10 : 2'b01;
  // Restart shares the reset path so both yield identical initial state.
  assign restart    = ((state == WIN) || (state == DRAW)) && btn_sel;

  // Wrapping neighbours of the cursor; the column wraps within its row.
  always_comb begin
    case (cursor)
      4'd1, 4'd4, 4'd7: col = 2'd1;
      4'd2, 4'd5, 4'd8: col = 2'd2;
      default:          col = 2'd0;
    endcase
    up_pos    = (cursor >= 4'd3) ? cursor - 4'd3 : cursor + 4'd6;
    down_pos  = (cursor <= 4'd5) ? cursor + 4'd3 : cursor - 4'd6;
    left_pos  = (col == 2'd0)    ? cursor + 4'd2 : cursor - 4'd1;
    right_pos = (col == 2'd2)    ? cursor - 4'd2 : cursor + 4'd1;
  end

  always_comb begin
    cur_cell = 2'b00;
    for (int i = 0; i < 9; i++) begin
      if (cursor == 4'(i)) cur_cell = board[i];
    end
  end

  // Line detection against the mark just placed; lines are rows, cols, diags.
  always_comb begin
    for (int i = 0; i < 9; i++) is_mark[i] = (board[i] == mover_mark);
    line_hit[0] = is_mark[0] & is_mark[1] & is_mark[2];
    line_hit[1] = is_mark[3] & is_mark[4] & is_mark[5];
    line_hit[2] = is_mark[6] & is_mark[7] & is_mark[8];
    line_hit[3] = is_mark[0] & is_mark[3] & is_mark[6];
    line_hit[4] = is_mark[1] & is_mark[4] & is_mark[7];
    line_hit[5] = is_mark[2] & is_mark[5] & is_mark[8];
    line_hit[6] = is_mark[0] & is_mark[4] & is_mark[8];
    line_hit[7] = is_mark[2] & is_mark[4] & is_mark[6];
    win_cells[0] = line_hit[0] | line_hit[3] | line_hit[6];
    win_cells[1] = line_hit[0] | line_hit[4];
    win_cells[2] = line_hit[0] | line_hit[5] | line_hit[7];
    win_cells[3] = line_hit[1] | line_hit[3];
    win_cells[4] = line_hit[1] | line_hit[4] | line_hit[6] | line_hit[7];
    win_cells[5] = line_hit[1] | line_hit[5];
    win_cells[6] = line_hit[2] | line_hit[3] | line_hit[7];
    win_cells[7] = line_hit[2] | line_hit[4];
    win_cells[8] = line_hit[2] | line_hit[5] | line_hit[6];
  end

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      state      <= PLAY_X;
      board      <= '0;
      move_count <= 4'd0;
      mover      <= 1'b0;
      cursor     <= 4'd4;
      turn       <= 1'b0;
      winner     <= 2'b00;
      game_over  <= 1'b0;
    end else begin
      case (state)
        PLAY_X, PLAY_O: begin
          if (btn_sel) begin
            // Occupied cell: the press is consumed with no effect.
            if (cur_cell == 2'b00) begin
              for (int i = 0; i < 9; i++) begin
                if (cursor == 4'(i)) board[i] <= (state == PLAY_O) ? 2'b10 : 2'b01;
              end
              move_count <= move_count + 4'd1;
              mover      <= (state == PLAY_O);
              state      <= CHECK;
            end
          end else if (btn_up) begin
            cursor <= up_pos;
          end else if (btn_down) begin
            cursor <= down_pos;
          end else if (btn_left) begin
            cursor <= left_pos;
          end else if (btn_right) begin
            cursor <= right_pos;
          end
        end
        CHECK: begin
          if (|line_hit) begin
            for (int i = 0; i < 9; i++) begin
              if (win_cells[i]) board[i] <= 2'b11;
            end
            winner    <= mover_mark;
            game_over <= 1'b1;
            state     <= WIN;
          end else if (move_count == 4'd9) begin
            winner    <= 2'b11;
            game_over <= 1'b1;
            state     <= DRAW;
          end else begin
            turn  <= ~turn;
            state <= mover ? PLAY_X : PLAY_O;
          end
        end
        WIN, DRAW: begin
        end
        default: state <= PLAY_X;
      endcase
    end
  end

  // Lookup port: one cycle of latency, sampling board/cursor of that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_mode <= 2'b00;
      rd_hl   <= 1'b0;
    end else begin
      rd_mode <= 2'b00;
      for (int i = 0; i < 9; i++) begin
        if (rd_cell == 4'(i)) rd_mode <= board[i];
      end
      rd_hl <= playing && (rd_cell == cursor);
    end
  end

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Self-checking bench for ttt_game_ctrl: a cursor vector table plus
// hand-written games (win, occupied select, draw, double line, mid-CHECK reset).
// Cell lookups go through an expected-value queue popped one cycle later.
module tb_ttt_game_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up, btn_down, btn_left, btn_right, btn_sel;
  logic [3:0] rd_cell;
  logic [1:0] rd_mode;
  logic       rd_hl;
  logic [3:0] cursor;
  logic       turn;
  logic [1:0] winner;
  logic       game_over;

  ttt_game_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_sel   (btn_sel),
    .rd_cell   (rd_cell),
    .rd_mode   (rd_mode),
    .rd_hl     (rd_hl),
    .cursor    (cursor),
    .turn      (turn),
    .winner    (winner),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  // Button encodings: {sel, up, down, left, right}
  localparam logic [4:0] SEL   = 5'b10000;
  localparam logic [4:0] UP    = 5'b01000;
  localparam logic [4:0] DOWN  = 5'b00100;
  localparam logic [4:0] LEFT  = 5'b00010;
  localparam logic [4:0] RIGHT = 5'b00001;

  typedef struct {
    logic [4:0] btns;
    logic [3:0] exp_cursor;
  } vec_t;

  int         checks = 0;
  int         fails  = 0;
  logic [2:0] exp_q[$];
  logic [1:0] exp_board [9];
  int         exp_cursor;
  logic       exp_turn;
  logic       exp_playing;
  vec_t       vecs [11];

  task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Called at a negedge: drive buttons across exactly one rising edge.
  task automatic applyStimulus(input logic [4:0] btns);
    {btn_sel, btn_up, btn_down, btn_left, btn_right} = btns;
    @(negedge clk);
    {btn_sel, btn_up, btn_down, btn_left, btn_right} = 5'b0;
  endtask

  task automatic resetModel();
    for (int i = 0; i < 9; i++) exp_board[i] = 2'b00;
    exp_cursor  = 4;
    exp_turn    = 1'b0;
    exp_playing = 1'b1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    resetModel();
  endtask

  task automatic lookup(input int idx);
    logic [2:0] exp;
    logic [2:0] got;
    rd_cell = 4'(idx);
    exp[2:1] = 2'b00;
    if (idx < 9) exp[2:1] = exp_board[idx];
    exp[0] = (idx == exp_cursor) && exp_playing;
    exp_q.push_back(exp);
    @(negedge clk);
    got = {rd_mode, rd_hl};
    exp = exp_q.pop_front();
    checkOutput($sformatf("lookup_cell%0d", idx), 8'(got), 8'(exp));
  endtask

  task automatic sweep();
    for (int i = 0; i <= 9; i++) lookup(i);
  endtask

  task automatic checkState(input string tag, input logic [1:0] exp_winner, input logic exp_over);
    checkOutput({tag, "_cursor"}, 8'(cursor), 8'(exp_cursor));
    checkOutput({tag, "_turn"}, 8'(turn), 8'(exp_turn));
    checkOutput({tag, "_winner"}, 8'(winner), 8'(exp_winner));
    checkOutput({tag, "_game_over"}, 8'(game_over), 8'(exp_over));
  endtask

  task automatic moveTo(input int target);
    while (exp_cursor / 3 != target / 3) begin
      applyStimulus(DOWN);
      exp_cursor = (exp_cursor < 6) ? exp_cursor + 3 : exp_cursor - 6;
      checkOutput("nav_down", 8'(cursor), 8'(exp_cursor));
    end
    while (exp_cursor % 3 != target % 3) begin
      applyStimulus(RIGHT);
      exp_cursor = (exp_cursor % 3 == 2) ? exp_cursor - 2 : exp_cursor + 1;
      checkOutput("nav_right", 8'(cursor), 8'(exp_cursor));
    end
  endtask

  // Place the current player's mark; returns two cycles after btn_sel.
  task automatic place(input int target, input bit last);
    moveTo(target);
    applyStimulus(SEL);
    exp_board[target] = exp_turn ? 2'b10 : 2'b01;
    checkOutput("winner_at_t1", 8'(winner), 8'h00);
    @(negedge clk);
    if (!last) exp_turn = ~exp_turn;
    checkOutput("turn_after_place", 8'(turn), 8'(exp_turn));
  endtask

  task automatic doubleLineSetup();
    place(0, 0); place(1, 0); place(2, 0); place(3, 0);
    place(6, 0); place(5, 0); place(8, 0); place(7, 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    {btn_sel, btn_up, btn_down, btn_left, btn_right} = 5'b0;
    rd_cell = 4'd0;
    resetModel();
    repeat (2) @(negedge clk);
    checkOutput("reset_rd_mode", 8'(rd_mode), 8'h00);
    checkOutput("reset_rd_hl", 8'(rd_hl), 8'h00);
    checkState("reset", 2'b00, 1'b0);
    rst = 1'b0;
    sweep();

    // Cursor movement table, including wraps and same-cycle priority.
    vecs[0]  = '{UP, 4'd1};
    vecs[1]  = '{UP, 4'd7};
    vecs[2]  = '{LEFT, 4'd6};
    vecs[3]  = '{LEFT, 4'd8};
    vecs[4]  = '{LEFT, 4'd7};
    vecs[5]  = '{DOWN, 4'd1};
    vecs[6]  = '{RIGHT, 4'd2};
    vecs[7]  = '{RIGHT, 4'd0};
    vecs[8]  = '{UP | DOWN | LEFT, 4'd6};
    vecs[9]  = '{LEFT | RIGHT, 4'd8};
    vecs[10] = '{DOWN | RIGHT, 4'd2};
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].btns);
      checkOutput($sformatf("cursor_vec%0d", i), 8'(cursor), 8'(vecs[i].exp_cursor));
    end

    // X wins top row, then ignored moves, then restart.
    doReset();
    place(0, 0); place(3, 0); place(1, 0); place(4, 0); place(2, 1);
    exp_board[0] = 2'b11; exp_board[1] = 2'b11; exp_board[2] = 2'b11;
    exp_playing = 1'b0;
    checkState("xwin", 2'b01, 1'b1);
    sweep();
    applyStimulus(UP);
    applyStimulus(LEFT);
    checkState("xwin_moves", 2'b01, 1'b1);
    applyStimulus(SEL);
    resetModel();
    checkState("restart", 2'b00, 1'b0);
    sweep();

    // Occupied select, select+up priority, buttons in CHECK, then a draw.
    doReset();
    place(4, 0);
    applyStimulus(SEL);
    @(negedge clk);
    checkOutput("occupied_turn", 8'(turn), 8'h01);
    lookup(4);
    moveTo(0);
    applyStimulus(SEL | UP);
    checkOutput("sel_up_cursor", 8'(cursor), 8'h00);
    applyStimulus(RIGHT);
    exp_board[0] = 2'b10;
    exp_turn = 1'b0;
    checkState("sel_up", 2'b00, 1'b0);
    applyStimulus(SEL);
    @(negedge clk);
    checkOutput("occupied_turn2", 8'(turn), 8'h00);
    place(1, 0); place(7, 0); place(3, 0); place(5, 0); place(6, 0); place(2, 0); place(8, 1);
    exp_playing = 1'b0;
    checkState("draw_a", 2'b11, 1'b1);
    sweep();

    // Reference draw game.
    doReset();
    place(0, 0); place(1, 0); place(2, 0); place(4, 0); place(3, 0);
    place(5, 0); place(7, 0); place(6, 0); place(8, 1);
    exp_playing = 1'b0;
    checkState("draw_b", 2'b11, 1'b1);
    sweep();

    // Double line through the centre.
    doReset();
    doubleLineSetup();
    place(4, 1);
    exp_board[0] = 2'b11; exp_board[2] = 2'b11; exp_board[4] = 2'b11;
    exp_board[6] = 2'b11; exp_board[8] = 2'b11;
    exp_playing = 1'b0;
    checkState("double", 2'b01, 1'b1);
    sweep();

    // Same position, reset asserted in the CHECK cycle.
    doReset();
    doubleLineSetup();
    moveTo(4);
    applyStimulus(SEL);
    doReset();
    checkState("check_reset", 2'b00, 1'b0);
    sweep();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ttt_game_ctrl.md
# ttt_game_ctrl

Turn sequencer and board-state owner for the tic-tac-toe display. Takes single-cycle button pulses, moves a 3x3 cursor, and places X/O marks in alternating turns. After each placement it checks for a win or draw and recolours winning cells. It answers per-cell lookups from the pixel pipeline with the 2-bit cell mode and a highlight flag, in the encoding the renderer consumes.

## Interface
- No parameters; board is fixed 3x3, cells indexed 0..8 = row*3+col.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- btn_up, btn_down, btn_left, btn_right, btn_sel  in  1 each  one-cycle pulses from debouncer
- rd_cell  in  4  cell index requested by pixel pipeline
- rd_mode  out  2  mode of rd_cell: 00 empty, 01 X, 10 O, 11 winning cell
- rd_hl  out  1  1 when rd_cell == cursor and state is PLAY_X/PLAY_O
- cursor  out  4  current cursor cell, 0..8
- turn  out  1  0 = X to move, 1 = O to move
- winner  out  2  00 none, 01 X, 10 O, 11 draw
- game_over  out  1  1 in WIN or DRAW

## Operation
- Board: 9 x 2-bit registers; move_count 4-bit, 0..9.
- States: PLAY_X, PLAY_O, CHECK, WIN, DRAW.
- One action per cycle, priority btn_sel > up > down > left > right; lower-priority pulses in the same cycle are dropped.
- Cursor moves in PLAY_* only. Up/down change row by -1/+1 with wrap (0<->2). Left/right change column by -1/+1 with wrap within the row.
- btn_sel in PLAY_*:
  - Cell empty: write 01 (PLAY_X) or 10 (PLAY_O), increment move_count, go to CHECK. The state the cycle came from is remembered as the mover.
  - Cell occupied: no effect.
- CHECK (one cycle) evaluates all 8 lines (3 rows, 3 cols, 0-4-8, 2-4-6) for the mover's mark.
  - Any line complete: every cell on every completed line becomes 11; winner = mover encoding; go to WIN.
  - Else if move_count == 9: winner = 11; go to DRAW.
  - Else: toggle turn; go to the other PLAY state.
- All buttons are ignored in CHECK.
- WIN/DRAW: movement is ignored. btn_sel restarts the game: board all 00, move_count 0, cursor 4, turn 0, winner 00, state PLAY_X.
- Lookup: rd_cell 0..8 returns the board cell. rd_cell >= 9 returns rd_mode 00 and rd_hl 0.
- Reset values: board 00 in all cells, move_count 0, cursor 4, turn 0, winner 00, game_over 0, state PLAY_X, rd_mode 00, rd_hl 0.

## Timing
- All outputs are registered.
- Cursor update is visible on cursor one cycle after the button pulse.
- Placement with btn_sel at cycle t:
  - Cell written and state = CHECK at t+1.
  - Winner, winning-cell recolour (11), turn toggle, and next state take effect at t+2.
  - A btn_sel at t+1 is ignored (state is CHECK).
- rd_mode/rd_hl have 1-cycle latency from rd_cell and reflect board/cursor state as of the lookup cycle. The pixel pipeline compensates for this cycle.
- rst overrides every input in its cycle, including mid-CHECK and in WIN/DRAW. All state takes reset values on the next edge.
- Restart from WIN/DRAW takes effect on the edge after btn_sel; state = PLAY_X at t+1.
- Winning cells are written only in the CHECK cycle; they are never partially updated.

## Test plan
- Reset, then sweep rd_cell 0..9 -> all rd_mode 00; rd_hl 1 only for rd_cell = 4 (one cycle later); cursor 4, turn 0, winner 00.
- From cursor 4: up, up, left, left, left, down -> cursor sequence 1, 7, 6, 8, 7, 1.
- X wins top row, playing X0, O3, X1, O4, X2 -> two cycles after the last btn_sel, cells 0/1/2 read 11, cells 3/4 read 10, winner 01, game_over 1. Further moves and selects are ignored except btn_sel, which restarts to an all-00 board, cursor 4, turn 0.
- btn_sel on an occupied cell (X at 4, O moves there) -> cell stays 01, turn stays 1, move_count unchanged. btn_sel together with btn_up in the same cycle -> placement only; cursor unchanged.
- Draw, playing X0, O1, X2, O4, X3, O5, X7, O6, X8 -> winner 11, game_over 1, no cell reads 11.
- Double line: pre-place X at 0, 2, 6, 8 (O elsewhere); X selects 4 -> cells 0, 2, 4, 6, 8 all read 11. Asserting rst in the CHECK cycle instead -> next cycle is the full reset state, winner 00.
